decode_stage_sb: RTL and testbench
==================================

Name: decode_stage_sb

Overview:
- Registered instruction-decode stage with a per-register write scoreboard; next generation of the combinational ID decoder.
- Sits between fetch (IF) and execute (EX) in the ring-node CPU.
- Splits the 32-bit big-endian-indexed instruction into fields and derives the write enable.
- Blocks issue on read-after-write (RAW) and write-after-write (WAW) hazards until writeback, via valid/ready handshakes on both sides.

Parameters:
- INST_W, 32, instruction width. Field positions below assume 32.
- NUM_REGS, 32, register-file entries. Register-address width RA_W = clog2(NUM_REGS), 5 at default.
- PEND_W, 2, width of each per-register pending-write counter. Saturates at 2^PEND_W-1.
- ZERO_REG, 1, when 1: register 0 never counts as pending and is never tracked.
- CNT_W, 16, width of the hazard-stall performance counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents an instruction.
- if_inst  in  [0:INST_W-1]  instruction word, bit 0 = MSB.
- id_ready  out  1  stage accepts if_inst this cycle.
- ex_valid  out  1  decoded entry valid.
- ex_ready  in  1  EX accepts the entry.
- ex_type  out  [0:5]  type field, inst[0:5].
- ex_rD, ex_rA, ex_rB  out  [0:RA_W-1] each  inst[6:10], inst[11:15], inst[16:20].
- ex_ppp  out  [0:2]  inst[21:23].
- ex_WW  out  [0:1]  inst[24:25]: 00 byte, 01 half, 10 word, 11 doubleword.
- ex_op  out  [0:5]  inst[26:31].
- ex_imm  out  [0:15]  inst[16:31].
- ex_wrEn  out  1  entry writes rD.
- wb_valid  in  1  writeback retires a write.
- wb_rD  in  [0:RA_W-1]  register retired.
- flush  in  1  discard the held entry (branch redirect).
- stall_cnt  out  [0:CNT_W-1]  cycles with if_valid=1 and id_ready=0 caused by a hazard.

Behaviour:
- Type codes (shared package):
  - RTYPE 101010: writes rD; reads rA, rB.
  - LOAD 100000: writes rD; reads rA.
  - STORE 100001: reads rA and rD.
  - BEZ 100010, BNEZ 100011: read rD.
  - NOP 111100: no reads, no writes.
  - Any other type is decoded as NOP: wrEn=0, no sources.
- Decode is combinational from if_inst. Results are registered on acceptance.
- Latency: inst accepted at edge N appears on ex_* with ex_valid=1 after edge N. Throughput is one instruction per cycle.
- Output register free = !ex_valid || ex_ready.
- hazard = any source register with pend>0, OR (wrEn && pend[rD] saturated). With ZERO_REG=1, register 0 is ignored.
- id_ready = free && !hazard && !flush. id_ready does not depend on if_valid.
- Accept = if_valid && id_ready. On accept:
  - Load decoded fields into ex_*, set ex_valid=1.
  - If wrEn and rD tracked: pend[rD] += 1.
- ex_valid && ex_ready with no new accept: ex_valid -> 0.
- Writeback: wb_valid decrements pend[wb_rD], floored at 0 (no underflow; a writeback to a zero counter is ignored).
- Same register incremented and decremented in one cycle: counter unchanged.
- Flush:
  - If ex_valid && !ex_ready && ex_wrEn, decrement pend[ex_rD], combined with the writeback rule (two decrements on the same register both apply, floored at 0).
  - ex_valid -> 0. No accept that cycle.
  - A flush coinciding with ex_ready=1 is a normal handoff: entry delivered, no revert.
- stall_cnt increments when if_valid && free && hazard && !flush. Saturates at all-ones.
- Reset, asynchronous and valid mid-operation:
  - All pend -> 0, ex_valid=0, stall_cnt=0.
  - All ex_* data outputs -> 0, ex_wrEn=0.
  - id_ready reflects combinational state (1 while reset is low and no flush).
- ex_* data outputs hold their value while ex_valid=1 and ex_ready=0.

Decomposition:
- Package decode_pkg holds:
  - type-code constants RTYPE, LOAD, STORE, BEZ, BNEZ, NOP;
  - WW_BYTE/HALF/WORD/DW;
  - field bit-position constants;
  - the decoded-entry struct {type, rD, rA, rB, ppp, WW, op, imm, wrEn}.
- Sub-module scoreboard (NUM_REGS, PEND_W, ZERO_REG):
  - inc port, dec port x2 (writeback, flush);
  - per-register pending/saturated outputs.
- Top module holds the decoder, output register, handshake and stall counter.

Test Plan:
- RTYPE rD=3, rA=1, rB=2 with ex_ready=1 -> ex_valid one cycle later with fields 3/1/2, ex_wrEn=1, pend[3]=1. Next RTYPE reading r3 -> id_ready=0, stall_cnt increments each cycle. wb_valid, wb_rD=3 -> id_ready=1 the next cycle.
- Back-to-back independent RTYPEs with ex_ready=1 -> one ex_valid per cycle, no stalls. ex_ready=0 -> ex_* held stable and id_ready=0.
- Four LOADs to r5 with ex_ready=1 and no writeback -> first three accepted (pend[5]=3), fourth stalls on saturation. One writeback to r5 -> fourth accepted, pend[5] back to 3.
- LOAD r7 held (ex_ready=0), then flush -> ex_valid=0, pend[7]=0. Flush plus wb_rD=7 in the same cycle with pend[7]=2 -> pend[7]=0.
- ZERO_REG=1: RTYPE rD=0 followed by a read of r0 -> no stall. Writeback to a zero counter leaves it at 0.
- Assert reset mid-stall with pend nonzero -> ex_valid and stall_cnt drop to 0 asynchronously and all counters clear. The previously hazarded instruction is accepted on the first cycle after reset release.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Purpose  : Shared type codes, field positions and decode helpers for ID.
// Revision : 1.0
// ============================================================================
package decode_pkg;

    localparam int INST_BITS = 32;
    localparam int REG_BITS  = 5;

    localparam logic [5:0] RTYPE = 6'b101010;
    localparam logic [5:0] LOAD  = 6'b100000;
    localparam logic [5:0] STORE = 6'b100001;
    localparam logic [5:0] BEZ   = 6'b100010;
    localparam logic [5:0] BNEZ  = 6'b100011;
    localparam logic [5:0] NOP   = 6'b111100;

    localparam logic [1:0] WW_BYTE = 2'b00;
    localparam logic [1:0] WW_HALF = 2'b01;
    localparam logic [1:0] WW_WORD = 2'b10;
    localparam logic [1:0] WW_DW   = 2'b11;

    // Bit 0 is the MSB of the instruction word.
    localparam int TYPE_HI = 0;
    localparam int TYPE_LO = 5;
    localparam int RD_HI   = 6;
    localparam int RD_LO   = 10;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 15;
    localparam int RB_HI   = 16;
    localparam int RB_LO   = 20;
    localparam int PPP_HI  = 21;
    localparam int PPP_LO  = 23;
    localparam int WW_HI   = 24;
    localparam int WW_LO   = 25;
    localparam int OP_HI   = 26;
    localparam int OP_LO   = 31;
    localparam int IMM_HI  = 16;
    localparam int IMM_LO  = 31;

    typedef struct packed {
        logic [0:5]          typ;
        logic [0:REG_BITS-1] rd;
        logic [0:REG_BITS-1] ra;
        logic [0:REG_BITS-1] rb;
        logic [0:2]          ppp;
        logic [0:1]          ww;
        logic [0:5]          op;
        logic [0:15]         imm;
        logic                wr_en;
    } entry_t;

    typedef struct packed {
        logic use_ra;
        logic use_rb;
        logic use_rd;
    } src_t;

    function automatic entry_t decode_fields(input logic [0:INST_BITS-1] inst);
        entry_t e;
        e.typ   = inst[TYPE_HI:TYPE_LO];
        e.rd    = inst[RD_HI:RD_LO];
        e.ra    = inst[RA_HI:RA_LO];
        e.rb    = inst[RB_HI:RB_LO];
        e.ppp   = inst[PPP_HI:PPP_LO];
        e.ww    = inst[WW_HI:WW_LO];
        e.op    = inst[OP_HI:OP_LO];
        e.imm   = inst[IMM_HI:IMM_LO];
        e.wr_en = (e.typ == RTYPE) || (e.typ == LOAD);
        return e;
    endfunction

    // Unrecognised type codes fall through to the all-zero (NOP) source set.
    function automatic src_t decode_srcs(input logic [0:5] typ);
        src_t s;
        s = '0;
        case (typ)
            RTYPE:     begin s.use_ra = 1'b1; s.use_rb = 1'b1; end
            LOAD:      s.use_ra = 1'b1;
            STORE:     begin s.use_ra = 1'b1; s.use_rd = 1'b1; end
            BEZ, BNEZ: s.use_rd = 1'b1;
            default:   s = '0;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_sb_scoreboard
// Purpose  : Per-register saturating pending-write counters.
// Revision : 1.0
// ============================================================================
module decode_stage_sb_scoreboard #(
    parameter  int NUM_REGS = 32,
    parameter  int PEND_W   = 2,
    parameter  int ZERO_REG = 1,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inc_en,
    input  logic [0:RA_W-1]     inc_idx,
    input  logic                dec_a_en,
    input  logic [0:RA_W-1]     dec_a_idx,
    input  logic                dec_b_en,
    input  logic [0:RA_W-1]     dec_b_idx,
    output logic [NUM_REGS-1:0] pend,
    output logic [NUM_REGS-1:0] sat
);

    localparam int SUM_W = PEND_W + 2;
    localparam logic [SUM_W-1:0] MAX_CNT = SUM_W'((1 << PEND_W) - 1);

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic [PEND_W-1:0] cnt_q;
        logic [PEND_W-1:0] cnt_d;
        logic [SUM_W-1:0]  sum;
        logic [SUM_W-1:0]  decs;
        logic [SUM_W-1:0]  diff;

        always_comb begin
            sum  = SUM_W'(cnt_q) + SUM_W'(inc_en && (inc_idx == RA_W'(r)));
            decs = SUM_W'(dec_a_en && (dec_a_idx == RA_W'(r)))
                 + SUM_W'(dec_b_en && (dec_b_idx == RA_W'(r)));
            diff = '0;
            if (sum >= decs) begin
                diff = sum - decs;
            end
            if (diff > MAX_CNT) begin
                diff = MAX_CNT;
            end
            cnt_d = diff[PEND_W-1:0];
            if (ZERO_REG != 0 && r == 0) begin
                cnt_d = '0;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign pend[r] = |cnt_q;
        assign sat[r]  = &cnt_q;
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage_sb.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_sb
// Purpose  : Registered decode stage with RAW/WAW write scoreboard.
// Revision : 1.0
// ============================================================================
module decode_stage_sb
    import decode_pkg::*;
#(
    parameter  int INST_W   = 32,
    parameter  int NUM_REGS = 32,
    parameter  int PEND_W   = 2,
    parameter  int ZERO_REG = 1,
    parameter  int CNT_W    = 16,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_valid,
    input  logic [0:INST_W-1] if_inst,
    output logic              id_ready,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [0:5]        ex_type,
    output logic [0:RA_W-1]   ex_rD,
    output logic [0:RA_W-1]   ex_rA,
    output logic [0:RA_W-1]   ex_rB,
    output logic [0:2]        ex_ppp,
    output logic [0:1]        ex_WW,
    output logic [0:5]        ex_op,
    output logic [0:15]       ex_imm,
    output logic              ex_wrEn,
    input  logic              wb_valid,
    input  logic [0:RA_W-1]   wb_rD,
    input  logic              flush,
    output logic [0:CNT_W-1]  stall_cnt
);

    entry_t              dec;
    src_t                src;
    entry_t              ex_q;
    entry_t              ex_d;
    logic                ex_valid_q;
    logic                ex_valid_d;
    logic [CNT_W-1:0]    stall_cnt_q;
    logic [CNT_W-1:0]    stall_cnt_d;
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] sat;
    logic                free;
    logic                hazard;
    logic                accept;
    logic                flush_revert;

    always_comb begin
        dec = decode_fields(if_inst);
        src = decode_srcs(dec.typ);
    end

    // Register 0 never reads as pending when untracked, so no special case here.
    always_comb begin
        hazard = (src.use_ra && pend[dec.ra])
              || (src.use_rb && pend[dec.rb])
              || (src.use_rd && pend[dec.rd])
              || (dec.wr_en  && sat[dec.rd]);
        free         = !ex_valid_q || ex_ready;
        id_ready     = free && !hazard && !flush;
        accept       = if_valid && id_ready;
        flush_revert = flush && ex_valid_q && !ex_ready && ex_q.wr_en;
    end

    always_comb begin
        ex_d        = ex_q;
        ex_valid_d  = ex_valid_q;
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            ex_d       = dec;
            ex_valid_d = 1'b1;
        end else if (flush || ex_ready) begin
            ex_valid_d = 1'b0;
        end
        if (if_valid && free && hazard && !flush && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q        <= '0;
            ex_valid_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            ex_valid_q  <= ex_valid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    decode_stage_sb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .PEND_W   (PEND_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .inc_en    (accept && dec.wr_en),
        .inc_idx   (dec.rd),
        .dec_a_en  (wb_valid),
        .dec_a_idx (wb_rD),
        .dec_b_en  (flush_revert),
        .dec_b_idx (ex_q.rd),
        .pend      (pend),
        .sat       (sat)
    );

    assign ex_valid  = ex_valid_q;
    assign ex_type   = ex_q.typ;
    assign ex_rD     = ex_q.rd;
    assign ex_rA     = ex_q.ra;
    assign ex_rB     = ex_q.rb;
    assign ex_ppp    = ex_q.ppp;
    assign ex_WW     = ex_q.ww;
    assign ex_op     = ex_q.op;
    assign ex_imm    = ex_q.imm;
    assign ex_wrEn   = ex_q.wr_en;
    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_sb
// Purpose  : Directed vector bench for decode_stage_sb.
// Revision : 1.0
// ============================================================================
module tb_decode_stage_sb;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [0:31] if_inst;
    logic        id_ready;
    logic        ex_valid;
    logic        ex_ready;
    logic [0:5]  ex_type;
    logic [0:4]  ex_rD;
    logic [0:4]  ex_rA;
    logic [0:4]  ex_rB;
    logic [0:2]  ex_ppp;
    logic [0:1]  ex_WW;
    logic [0:5]  ex_op;
    logic [0:15] ex_imm;
    logic        ex_wrEn;
    logic        wb_valid;
    logic [0:4]  wb_rD;
    logic        flush;
    logic [0:15] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [5:0] T_R  = 6'b101010;
    localparam logic [5:0] T_LD = 6'b100000;
    localparam logic [5:0] T_ST = 6'b100001;
    localparam logic [5:0] T_BZ = 6'b100010;
    localparam logic [5:0] T_NP = 6'b111100;
    localparam logic [5:0] T_XX = 6'b000111;

    decode_stage_sb dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .id_ready  (id_ready),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_type   (ex_type),
        .ex_rD     (ex_rD),
        .ex_rA     (ex_rA),
        .ex_rB     (ex_rB),
        .ex_ppp    (ex_ppp),
        .ex_WW     (ex_WW),
        .ex_op     (ex_op),
        .ex_imm    (ex_imm),
        .ex_wrEn   (ex_wrEn),
        .wb_valid  (wb_valid),
        .wb_rD     (wb_rD),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1);
    end

    typedef struct {
        logic        iv;
        logic [0:31] inst;
        logic        er;
        logic        wv;
        logic [4:0]  wrd;
        logic        fl;
        logic        e_rdy;
        logic        e_v;
        logic [4:0]  e_rd;
        logic        e_wr;
        int          e_st;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [0:31] mk(input logic [5:0] t, input int rd, input int ra, input int rb);
        logic [0:31] w;
        w = {t, 5'(rd), 5'(ra), 5'(rb), 11'b0};
        return w;
    endfunction

    function automatic vec_t vv(input logic iv, input logic [0:31] inst, input logic er,
                                input logic wv, input int wrd, input logic fl,
                                input logic rdy, input logic v, input int rd,
                                input logic wr, input int st);
        vec_t x;
        x.iv = iv; x.inst = inst; x.er = er; x.wv = wv; x.wrd = 5'(wrd); x.fl = fl;
        x.e_rdy = rdy; x.e_v = v; x.e_rd = 5'(rd); x.e_wr = wr; x.e_st = st;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // iv, inst, er, wv, wrd, fl | rdy, v, rd, wr, stall
        tbl.push_back(vv(1, mk(T_R, 3, 1, 2),   1, 0, 0, 0,  1, 1, 3, 1, 0));
        tbl.push_back(vv(1, mk(T_R, 4, 3, 0),   1, 0, 0, 0,  0, 0, 3, 1, 1));
        tbl.push_back(vv(1, mk(T_R, 4, 3, 0),   1, 0, 0, 0,  0, 0, 3, 1, 2));
        tbl.push_back(vv(1, mk(T_R, 4, 3, 0),   1, 1, 3, 0,  0, 0, 3, 1, 3));
        tbl.push_back(vv(1, mk(T_R, 4, 3, 0),   1, 0, 0, 0,  1, 1, 4, 1, 3));
        tbl.push_back(vv(1, mk(T_R, 5, 1, 2),   1, 0, 0, 0,  1, 1, 5, 1, 3));
        tbl.push_back(vv(1, mk(T_R, 6, 1, 2),   0, 0, 0, 0,  0, 1, 5, 1, 3));
        tbl.push_back(vv(1, mk(T_R, 6, 1, 2),   1, 0, 0, 0,  1, 1, 6, 1, 3));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  1, 1, 4, 0,  1, 0, 6, 1, 3));
        // r5 saturation: pend 1 -> 2 -> 3, then stall, writeback frees one slot
        tbl.push_back(vv(1, mk(T_LD, 5, 1, 0),  1, 0, 0, 0,  1, 1, 5, 1, 3));
        tbl.push_back(vv(1, mk(T_LD, 5, 1, 0),  1, 0, 0, 0,  1, 1, 5, 1, 3));
        tbl.push_back(vv(1, mk(T_LD, 5, 1, 0),  1, 0, 0, 0,  0, 0, 5, 1, 4));
        tbl.push_back(vv(1, mk(T_LD, 5, 1, 0),  1, 1, 5, 0,  0, 0, 5, 1, 5));
        tbl.push_back(vv(1, mk(T_LD, 5, 1, 0),  1, 0, 0, 0,  1, 1, 5, 1, 5));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  1, 1, 5, 0,  1, 0, 5, 1, 5));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  1, 1, 5, 0,  1, 0, 5, 1, 5));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  1, 1, 5, 0,  1, 0, 5, 1, 5));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  1, 1, 5, 0,  1, 0, 5, 1, 5));
        tbl.push_back(vv(1, mk(T_LD, 5, 1, 0),  1, 0, 0, 0,  1, 1, 5, 1, 5));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  1, 1, 5, 0,  1, 0, 5, 1, 5));
        // flush of a held write reverts its pending count
        tbl.push_back(vv(1, mk(T_LD, 7, 1, 0),  0, 0, 0, 0,  1, 1, 7, 1, 5));
        tbl.push_back(vv(1, mk(T_R, 8, 7, 0),   0, 0, 0, 1,  0, 0, 7, 1, 5));
        tbl.push_back(vv(1, mk(T_R, 8, 7, 0),   1, 0, 0, 0,  1, 1, 8, 1, 5));
        tbl.push_back(vv(1, mk(T_LD, 7, 1, 0),  1, 0, 0, 0,  1, 1, 7, 1, 5));
        tbl.push_back(vv(1, mk(T_LD, 7, 1, 0),  1, 0, 0, 0,  1, 1, 7, 1, 5));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  0, 1, 7, 1,  0, 0, 7, 1, 5));
        tbl.push_back(vv(1, mk(T_R, 9, 7, 0),   1, 0, 0, 0,  1, 1, 9, 1, 5));
        // register 0 is never pending
        tbl.push_back(vv(1, mk(T_R, 0, 1, 2),   1, 0, 0, 0,  1, 1, 0, 1, 5));
        tbl.push_back(vv(1, mk(T_R, 10, 0, 0),  1, 0, 0, 0,  1, 1, 10, 1, 5));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  1, 1, 0, 0,  1, 0, 10, 1, 5));
        // flush during a handoff keeps the write pending
        tbl.push_back(vv(1, mk(T_LD, 11, 1, 0), 1, 0, 0, 0,  1, 1, 11, 1, 5));
        tbl.push_back(vv(0, mk(T_NP, 0, 0, 0),  1, 0, 0, 1,  0, 0, 11, 1, 5));
        tbl.push_back(vv(1, mk(T_R, 12, 11, 0), 1, 0, 0, 0,  0, 0, 11, 1, 6));
        tbl.push_back(vv(1, mk(T_ST, 11, 1, 2), 1, 0, 0, 0,  0, 0, 11, 1, 7));
        tbl.push_back(vv(1, mk(T_BZ, 11, 0, 0), 1, 0, 0, 0,  0, 0, 11, 1, 8));
        tbl.push_back(vv(1, mk(T_XX, 11, 0, 0), 1, 0, 0, 0,  1, 1, 11, 0, 8));
        tbl.push_back(vv(1, mk(T_R, 12, 11, 0), 0, 0, 0, 0,  0, 1, 11, 0, 8));

        reset    = 1'b1;
        if_valid = 1'b0;
        if_inst  = '0;
        ex_ready = 1'b0;
        wb_valid = 1'b0;
        wb_rD    = '0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset ex_valid",  32'(ex_valid),  32'd0);
        check("reset stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset ex_rD",     32'(ex_rD),     32'd0);
        check("reset ex_wrEn",   32'(ex_wrEn),   32'd0);
        check("reset id_ready",  32'(id_ready),  32'd1);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            if_valid = tbl[i].iv;
            if_inst  = tbl[i].inst;
            ex_ready = tbl[i].er;
            wb_valid = tbl[i].wv;
            wb_rD    = tbl[i].wrd;
            flush    = tbl[i].fl;
            #1;
            check($sformatf("v%0d id_ready", i), 32'(id_ready), 32'(tbl[i].e_rdy));
            @(posedge clk);
            #1;
            check($sformatf("v%0d ex_valid", i),  32'(ex_valid),  32'(tbl[i].e_v));
            check($sformatf("v%0d ex_rD", i),     32'(ex_rD),     32'(tbl[i].e_rd));
            check($sformatf("v%0d ex_wrEn", i),   32'(ex_wrEn),   32'(tbl[i].e_wr));
            check($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].e_st));
        end

        // Asynchronous reset while an entry is held and r11 is pending
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("async ex_valid",  32'(ex_valid),  32'd0);
        check("async stall_cnt", 32'(stall_cnt), 32'd0);
        check("async ex_rD",     32'(ex_rD),     32'd0);
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        ex_ready = 1'b1;
        #1;
        check("post-reset id_ready", 32'(id_ready), 32'd1);
        @(posedge clk);
        #1;
        check("post-reset ex_valid",  32'(ex_valid),  32'd1);
        check("post-reset ex_rD",     32'(ex_rD),     32'd12);
        check("post-reset stall_cnt", 32'(stall_cnt), 32'd0);

        // Full field extraction
        @(negedge clk);
        if_inst = {T_R, 5'd13, 5'd14, 5'd15, 3'b101, 2'b10, 6'b110011};
        #1;
        check("fields id_ready", 32'(id_ready), 32'd1);
        @(posedge clk);
        #1;
        check("fields ex_type", 32'(ex_type), 32'h2A);
        check("fields ex_rD",   32'(ex_rD),   32'd13);
        check("fields ex_rA",   32'(ex_rA),   32'd14);
        check("fields ex_rB",   32'(ex_rB),   32'd15);
        check("fields ex_ppp",  32'(ex_ppp),  32'd5);
        check("fields ex_WW",   32'(ex_WW),   32'd2);
        check("fields ex_op",   32'(ex_op),   32'h33);
        check("fields ex_imm",  32'(ex_imm),  32'h7DB3);
        check("fields ex_wrEn", 32'(ex_wrEn), 32'd1);

        @(negedge clk);
        if_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain ex_valid", 32'(ex_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
